// File: rtl/mmu_req_arbiter.sv
// Merges fetch and load/store requests into the MMU's single request channel and
// routes in-order 64-bit responses back to the issuing port via a small tag FIFO.
module mmu_req_arbiter #(
  parameter int unsigned P_TAG_DEPTH   = 8,
  parameter int unsigned P_TAG_DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic [1:0]  iSYSREG_MOD,
  input  logic [2:0]  iSYSREG_MMUPS,
  input  logic [31:0] iSYSREG_PDT,
  input  logic        iINST_REQ,
  input  logic [31:0] iINST_ADDR,
  output logic        oINST_LOCK,
  input  logic        iLDST_REQ,
  output logic        oLDST_LOCK,
  input  logic        iLDST_DATA_STORE_ACK,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [3:0]  iLDST_MASK,
  input  logic        iLDST_RW,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLOGIC_REQ,
  input  logic        iLOGIC_LOCK,
  output logic        oLOGIC_DATA_STORE_ACK,
  output logic [1:0]  oLOGIC_MOD,
  output logic [2:0]  oLOGIC_MMUPS,
  output logic [31:0] oLOGIC_PDT,
  output logic [1:0]  oLOGIC_ORDER,
  output logic [3:0]  oLOGIC_MASK,
  output logic        oLOGIC_RW,
  output logic [31:0] oLOGIC_ADDR,
  output logic [31:0] oLOGIC_DATA,
  input  logic        iRESP_VALID,
  input  logic [63:0] iRESP_DATA,
  output logic        oRESP_LOCK,
  output logic        oINST_VALID,
  output logic [63:0] oINST_DATA,
  input  logic        iINST_BUSY,
  output logic        oLDST_VALID,
  output logic [63:0] oLDST_DATA,
  input  logic        iLDST_BUSY,
  output logic        oRESP_ORPHAN
);

  localparam int unsigned PTR_W = P_TAG_DEPTH_N + 1;
  localparam int unsigned IDX_W = P_TAG_DEPTH_N;

  typedef struct packed {
    logic        dsa;
    logic [1:0]  mod;
    logic [2:0]  mmups;
    logic [31:0] pdt;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic                   req_valid_q, req_valid_d;
  req_t                   req_q, req_d;
  logic                   last_grant_q, last_grant_d;
  logic [P_TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   orphan_q, orphan_d;

  logic fifo_empty, fifo_full, accept_ok;
  logic grant_inst, grant_ldst, acc_inst, acc_ldst;
  logic push, pop, head_tag, head_busy;

  // Arbitration and acceptance; a losing port only sees lock when the other port is requesting.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign accept_ok  = (!req_valid_q || !iLOGIC_LOCK) && !fifo_full;
  assign grant_inst = !iLDST_REQ || last_grant_q;
  assign grant_ldst = !iINST_REQ || !last_grant_q;
  assign oINST_LOCK = !accept_ok || !grant_inst;
  assign oLDST_LOCK = !accept_ok || !grant_ldst;
  assign acc_inst   = iINST_REQ && !oINST_LOCK;
  assign acc_ldst   = iLDST_REQ && !oLDST_LOCK;
  assign push       = acc_inst || (acc_ldst && (!iLDST_RW || iLDST_DATA_STORE_ACK));

  // Response steering from the FIFO head, zero latency.
  assign head_tag    = tag_q[rd_ptr_q[IDX_W-1:0]];
  assign head_busy   = head_tag ? iLDST_BUSY : iINST_BUSY;
  assign oRESP_LOCK  = !fifo_empty && head_busy;
  assign pop         = iRESP_VALID && !oRESP_LOCK && !fifo_empty;
  assign oINST_VALID = iRESP_VALID && !fifo_empty && !head_tag;
  assign oLDST_VALID = iRESP_VALID && !fifo_empty && head_tag;
  assign oINST_DATA  = iRESP_DATA;
  assign oLDST_DATA  = iRESP_DATA;

  always_comb begin
    req_valid_d  = req_valid_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    orphan_d     = iRESP_VALID && fifo_empty;

    if (req_valid_q && !iLOGIC_LOCK) begin
      req_valid_d = 1'b0;
    end

    if (acc_inst || acc_ldst) begin
      req_valid_d  = 1'b1;
      last_grant_d = acc_ldst;
      req_d.mod    = iSYSREG_MOD;
      req_d.mmups  = iSYSREG_MMUPS;
      req_d.pdt    = iSYSREG_PDT;
      if (acc_inst) begin
        req_d.dsa   = 1'b0;
        req_d.order = 2'h2;
        req_d.mask  = 4'hf;
        req_d.rw    = 1'b0;
        req_d.addr  = iINST_ADDR;
        req_d.data  = 32'h0;
      end else begin
        req_d.dsa   = iLDST_DATA_STORE_ACK;
        req_d.order = iLDST_ORDER;
        req_d.mask  = iLDST_MASK;
        req_d.rw    = iLDST_RW;
        req_d.addr  = iLDST_ADDR;
        req_d.data  = iLDST_DATA;
      end
    end

    if (push) begin
      tag_d[wr_ptr_q[IDX_W-1:0]] = acc_ldst;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Synchronous clear drops the held request and every outstanding tag.
    if (iRESET_SYNC) begin
      req_valid_d  = 1'b0;
      req_d        = '0;
      last_grant_d = 1'b1;
      tag_d        = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      orphan_d     = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      req_valid_q  <= 1'b0;
      req_q        <= '0;
      last_grant_q <= 1'b1;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      orphan_q     <= 1'b0;
    end else begin
      req_valid_q  <= req_valid_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      orphan_q     <= orphan_d;
    end
  end

  assign oLOGIC_REQ            = req_valid_q;
  assign oLOGIC_DATA_STORE_ACK = req_q.dsa;
  assign oLOGIC_MOD            = req_q.mod;
  assign oLOGIC_MMUPS          = req_q.mmups;
  assign oLOGIC_PDT            = req_q.pdt;
  assign oLOGIC_ORDER          = req_q.order;
  assign oLOGIC_MASK           = req_q.mask;
  assign oLOGIC_RW             = req_q.rw;
  assign oLOGIC_ADDR           = req_q.addr;
  assign oLOGIC_DATA           = req_q.data;
  assign oRESP_ORPHAN          = orphan_q;

endmodule
